// File: rtl/result_pkt_sender.sv
// result_pkt_sender: saturates (addr, value) pairs into 32-bit result packets,
// buffers them in a small FIFO and streams them over a valid/ready channel,
// counting frames of DEPTH_R*DEPTH_R packets.
// Optional build macro: SPIKE_PRETHRESH_EN (pre-threshold the data field and
// set the spike flag in bit 26).
module result_pkt_sender #(
  parameter int unsigned            WIDTH_DATA = 13,
  parameter int unsigned            WIDTH_IN   = 16,
  parameter int unsigned            WIDTH_ADDR = 9,
  parameter int unsigned            WIDTH_PKT  = 32,
  parameter int unsigned            DEPTH_R    = 21,
  parameter int unsigned            FIFO_DEPTH = 4,
  parameter logic [3:0]             DEST_ID    = 4'd0,
  parameter logic [WIDTH_DATA-1:0]  THRE       = 13'd64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH_ADDR-1:0]        in_addr,
  input  logic signed [WIDTH_IN-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH_PKT-1:0]         out_pkt,
  output logic                         frame_done,
  output logic                         err_addr,
  output logic [WIDTH_ADDR-1:0]        pkt_count
);

  localparam int unsigned             FRAME     = DEPTH_R * DEPTH_R;
  localparam logic [WIDTH_ADDR-1:0]   LAST_ADDR = WIDTH_ADDR'(FRAME - 1);
  localparam int unsigned             AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned             CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]           FULL_CNT  = CW'(FIFO_DEPTH);

  logic [WIDTH_PKT-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]         count, cnt_after_pop, cnt_nxt;
  logic                  rdy_q;
  logic                  accept, addr_ok, push, pop;
  logic [WIDTH_DATA-1:0] sat, field;
  logic                  spike;
  logic [WIDTH_PKT-1:0]  pkt_word, head_nxt;

  assign in_ready = rdy_q && (count != FULL_CNT);
  assign accept   = in_valid && in_ready;
  assign addr_ok  = (in_addr <= LAST_ADDR);
  assign push     = accept && addr_ok;
  assign pop      = out_valid && out_ready;

  // Saturate, optionally pre-threshold, and pack the incoming pair.
  always_comb begin
    if (in_data[WIDTH_IN-1])
      sat = '0;
    else if (|in_data[WIDTH_IN-2:WIDTH_DATA])
      sat = '1;
    else
      sat = in_data[WIDTH_DATA-1:0];
    field = sat;
    spike = 1'b0;
`ifdef SPIKE_PRETHRESH_EN
    if (sat >= THRE) begin
      field = sat - THRE;
      spike = 1'b1;
    end
`endif
    pkt_word = '0;
    pkt_word[WIDTH_DATA-1:0]                = field;
    pkt_word[WIDTH_DATA +: WIDTH_ADDR]      = in_addr;
    pkt_word[WIDTH_DATA+WIDTH_ADDR +: 4]    = DEST_ID;
    pkt_word[WIDTH_DATA+WIDTH_ADDR+4]       = spike;
  end

  // Next FIFO occupancy and the word that will sit at the head after this edge.
  // A push into an otherwise-empty FIFO bypasses memory so the output register
  // picks it up on the same edge (one-cycle latency).
  always_comb begin
    rd_nxt        = pop ? rd_ptr + AW'(1) : rd_ptr;
    cnt_after_pop = pop ? count - CW'(1) : count;
    cnt_nxt       = push ? cnt_after_pop + CW'(1) : cnt_after_pop;
    head_nxt      = (cnt_after_pop == '0) ? pkt_word : mem[rd_nxt];
  end

  // Input-ready enable: low in reset, high from the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt_word;
  end

  // Registered output stage mirrors the FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pkt   <= '0;
    end else begin
      out_valid <= (cnt_nxt != '0);
      if (cnt_nxt != '0) out_pkt <= head_nxt;
    end
  end

  // Frame counter, completion pulse and sticky address error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count  <= '0;
      frame_done <= 1'b0;
      err_addr   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        if (pkt_count == LAST_ADDR) begin
          pkt_count  <= '0;
          frame_done <= 1'b1;
        end else begin
          pkt_count <= pkt_count + WIDTH_ADDR'(1);
        end
      end
      if (accept && !addr_ok) err_addr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_pkt_sender.sv
// Self-checking bench for result_pkt_sender: constant vector table, directed
// corner sequences, and randomized traffic against a queue-based model.
module tb_result_pkt_sender;

  localparam int FRAME = 441;
`ifdef SPIKE_PRETHRESH_EN
  localparam bit SPK = 1'b1;
`else
  localparam bit SPK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [8:0]        in_addr = '0;
  logic signed [15:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pkt;
  logic              frame_done;
  logic              err_addr;
  logic [8:0]        pkt_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  result_pkt_sender dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
    .frame_done(frame_done), .err_addr(err_addr), .pkt_count(pkt_count)
  );

  typedef struct {
    logic [8:0]         addr;
    logic signed [15:0] data;
    logic [31:0]        exp;
  } vec_t;

  // Reference model state
  logic [31:0] exp_q[$];
  int  m_sent = 0;
  bit  m_fd = 1'b0;
  bit  m_err = 1'b0;
  bit  mon_en = 1'b0;
  int  fd_seen = 0;

  function automatic logic [31:0] model_pkt(int addr, int data);
    int d;
    int s;
    d = (data < 0) ? 0 : ((data > 8191) ? 8191 : data);
    s = 0;
    if (SPK && d >= 64) begin
      d = d - 64;
      s = 1;
    end
    return 32'(s * (1 << 26) + addr * (1 << 13) + d);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle monitor: compare outputs with the model, then advance the model
  // by what the coming edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      bit acc, xfer;
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("out_pkt", out_pkt, exp_q[0]);
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 4));
      chk("pkt_count", 32'(pkt_count), 32'(m_sent));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("err_addr", 32'(err_addr), 32'(m_err));
      if (frame_done) fd_seen++;
      acc  = in_valid && (exp_q.size() < 4);
      xfer = out_ready && (exp_q.size() != 0);
      m_fd = 1'b0;
      if (xfer) begin
        void'(exp_q.pop_front());
        m_sent++;
        if (m_sent == FRAME) begin
          m_sent = 0;
          m_fd = 1'b1;
        end
      end
      if (acc) begin
        if (int'(in_addr) < FRAME) exp_q.push_back(model_pkt(int'(in_addr), int'(in_data)));
        else m_err = 1'b1;
      end
    end
  end

  // Hold reset for a few edges, release, and check in_ready timing.
  task automatic do_reset();
    mon_en   = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready_at_release", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready_first_edge", 32'(in_ready), 32'd1);
    exp_q.delete();
    m_sent = 0;
    m_fd   = 1'b0;
    m_err  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Called with in_valid already high; returns #1 after the accepting edge.
  task automatic wait_accept();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n >= 100) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(int addr, int data);
    in_addr  = 9'(addr);
    in_data  = 16'(data);
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    int pc_before;

    vecs[0] = '{9'd5,   16'sd100,    SPK ? 32'h0400A024 : 32'h0000A064};
    vecs[1] = '{9'd7,   -16'sd3,     32'h0000E000};
    vecs[2] = '{9'd8,   16'sd9000,   SPK ? 32'h04011FBF : 32'h00011FFF};
    vecs[3] = '{9'd9,   16'sd8191,   SPK ? 32'h04013FBF : 32'h00013FFF};
    vecs[4] = '{9'd0,   16'sd0,      32'h00000000};
    vecs[5] = '{9'd440, 16'sd8192,   SPK ? 32'h04371FBF : 32'h00371FFF};
    vecs[6] = '{9'd1,   16'sd63,     32'h0000203F};
    vecs[7] = '{9'd2,   16'sd64,     SPK ? 32'h04004000 : 32'h00004040};
    vecs[8] = '{9'd3,   -16'sd32768, 32'h00006000};
    vecs[9] = '{9'd4,   16'sd32767,  SPK ? 32'h04009FBF : 32'h00009FFF};

    // Reset values while rst_n is held low
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pkt", out_pkt, 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    do_reset();

    // Vector table: one pair each, packet visible the cycle after accept
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(int'(vecs[i].addr), int'(vecs[i].data));
      @(negedge clk);
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_pkt", out_pkt, vecs[i].exp);
      idle(1);
    end
    idle(3);

    // Backpressure: four fill the buffer, the fifth waits
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(10 + i, 200 + i);
    in_addr  = 9'd20;
    in_data  = 16'sd300;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_pkt", out_pkt, SPK ? 32'h04014088 : 32'h000140C8);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept();
    idle(8);

    // Bad address: dropped, error sticky
    chk("bad_err_before", 32'(err_addr), 32'd0);
    pc_before = int'(pkt_count);
    send(441, 10);
    @(negedge clk);
    chk("bad_no_pkt", 32'(out_valid), 32'd0);
    chk("bad_err_set", 32'(err_addr), 32'd1);
    @(negedge clk);
    chk("bad_count_same", 32'(pkt_count), 32'(pc_before));
    idle(1);
    for (int i = 0; i < 100; i++) send(int'($urandom_range(0, 440)), int'($urandom_range(0, 20000)) - 5000);
    idle(6);
    @(negedge clk);
    chk("bad_err_sticky", 32'(err_addr), 32'd1);
    idle(1);

    // Two back-to-back full frames
    do_reset();
    out_ready = 1'b1;
    fd_seen = 0;
    for (int f = 0; f < 2; f++)
      for (int a = 0; a < FRAME; a++) send(a, int'($urandom_range(0, 20000)) - 5000);
    idle(4);
    @(negedge clk);
    chk("frame_pulses", 32'(fd_seen), 32'd2);
    chk("frame_count_zero", 32'(pkt_count), 32'd0);
    idle(1);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 1500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_addr   = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(441, 511)) : 9'($urandom_range(0, 440));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(8);

    // Reset mid-frame with three packets buffered
    do_reset();
    for (int i = 0; i < 5; i++) send(30 + i, 50 + i);
    idle(4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(40 + i, 70 + i);
    @(negedge clk);
    chk("mid_count_before", 32'(pkt_count), 32'd5);
    @(posedge clk);
    #1 mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_pkt_count", 32'(pkt_count), 32'd0);
    chk("mid_frame_done", 32'(frame_done), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    do_reset();
    out_ready = 1'b1;
    send(5, 100);
    @(negedge clk);
    chk("post_rst_pkt", out_pkt, SPK ? 32'h0400A024 : 32'h0000A064);
    @(negedge clk);
    chk("post_rst_count", 32'(pkt_count), 32'd1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
